// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the shift-add multiplier controller
package mult_pkg;
  localparam int MULT_N = 4;
  typedef enum logic [6:0] {
    IDLE  = 7'b0000001,
    CLEAR = 7'b0000010,
    LOAD  = 7'b0000100,
    ADD   = 7'b0001000,
    SHB   = 7'b0010000,
    SHP   = 7'b0100000,
    DONE  = 7'b1000000
  } mult_state_t;
endpackage

// File: rtl/mult_ctrl.sv
// mult_ctrl: one-hot sequencer issuing clr/ld/ldp/shb/shp strobes to the shift-add multiplier datapath
// Ports: clk, clr_n (async active-low reset), start, b0 (datapath B LSB) in;
//        clr, ld, ldp, shb, shp strobes plus busy and done status out.
// Build option MULT_CTRL_SKIP_ZERO_EN: gate ldp with b0 so zero multiplier bits skip the add.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic b0,
  output logic clr,
  output logic ld,
  output logic ldp,
  output logic shb,
  output logic shp,
  output logic busy,
  output logic done
);
  localparam int CW = $clog2(N) + 1;
  mult_state_t st, nxt;
  logic [CW-1:0] cnt, nxt_cnt;
  always_comb begin
    nxt = st;
    nxt_cnt = cnt;
    unique case (st)
      IDLE:  nxt = start ? CLEAR : IDLE;
      CLEAR: nxt = LOAD;
      LOAD: begin
        nxt = ADD;
        nxt_cnt = CW'(1);
      end
      ADD:   nxt = (cnt == CW'(N)) ? DONE : SHB;
      SHB:   nxt = SHP;
      SHP: begin
        nxt = ADD;
        nxt_cnt = cnt + CW'(1);
      end
      DONE:  nxt = IDLE;
      default: begin
        nxt = IDLE;
        nxt_cnt = '0;
      end
    endcase
  end
  // busy gets its own flop so every status output comes straight from a register
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      st <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt_cnt;
      busy <= (nxt != IDLE);
    end
  assign clr  = (st == CLEAR);
  assign ld   = (st == LOAD);
  assign shb  = (st == SHB);
  assign shp  = (st == SHP);
  assign done = (st == DONE);
`ifdef MULT_CTRL_SKIP_ZERO_EN
  assign ldp = (st == ADD) & b0;
`else
  // datapath gates the add itself; b0 is not needed here
  logic unused_b0;
  assign unused_b0 = b0;
  assign ldp = (st == ADD);
`endif
endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: directed self-checking bench for mult_ctrl driving a behavioural shift-add datapath
module tb_mult_ctrl;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
  logic b0;
  logic clr, ld, ldp, shb, shp, busy, done;
  logic [3:0] da = '0, db = '0, a_r = '0, b_r = '0;
  logic [7:0] p_r = '0;
  int tests = 0, fails = 0, n_ldp = 0, n_shb = 0, multi = 0;
  string log_s = "";

  mult_ctrl dut (
    .clk(clk), .clr_n(clr_n), .start(start), .b0(b0),
    .clr(clr), .ld(ld), .ldp(ldp), .shb(shb), .shp(shp),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // datapath: LSB-first, each set bit adds A<<3 to P; N-1 right shifts land bit i at A<<i
  assign b0 = b_r[0];
  always @(posedge clk) begin
    if (clr) p_r <= '0;
    if (ld) begin
      a_r <= da;
      b_r <= db;
    end
    if (ldp && b_r[0]) p_r <= p_r + {1'b0, a_r, 3'b000};
    if (shb) b_r <= b_r >> 1;
    if (shp) p_r <= p_r >> 1;
  end

  always @(negedge clk) begin
    if (int'(clr) + int'(ld) + int'(ldp) + int'(shb) + int'(shp) + int'(done) > 1) multi++;
    if (clr) log_s = {log_s, "c"};
    if (ld) log_s = {log_s, "l"};
    if (ldp) begin
      log_s = {log_s, "a"};
      n_ldp++;
    end
    if (shb) begin
      log_s = {log_s, "b"};
      n_shb++;
    end
    if (shp) log_s = {log_s, "p"};
    if (done) log_s = {log_s, "d"};
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 60) begin
      @(negedge clk);
      g++;
    end
    check(tag, int'(done), 1);
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y);
    int lat;
    string exp_s;
    int exp_ldp;
    exp_s = "cl";
    exp_ldp = 0;
    for (int i = 0; i < 4; i++) begin
`ifdef MULT_CTRL_SKIP_ZERO_EN
      if (y[i]) begin
`else
      begin
`endif
        exp_s = {exp_s, "a"};
        exp_ldp++;
      end
      if (i < 3) exp_s = {exp_s, "bp"};
    end
    exp_s = {exp_s, "d"};
    @(negedge clk);
    da = x;
    db = y;
    log_s = "";
    n_ldp = 0;
    n_shb = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("clr_lat", int'(clr), 1);
    @(negedge clk);
    check("ld_lat", int'(ld), 1);
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    #1;
    check("latency", lat, 13);
    check("product", int'(p_r), int'(x) * int'(y));
    check("ldp_cnt", n_ldp, exp_ldp);
    check("shb_cnt", n_shb, 3);
    check("order", int'(log_s == exp_s), 1);
  endtask

  initial begin
    int seen, g;
    // reset held with start high
    clr_n = 1'b0;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outs", int'({clr, ld, ldp, shb, shp, busy, done}), 0);
    clr_n = 1'b1;
    da = 4'b1011;
    db = 4'b1101;
    @(negedge clk);
    check("rst_rel_clr", int'(clr), 1);
    check("rst_rel_busy", int'(busy), 1);
    start = 1'b0;
    wait_done("rst_op_done");
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    run_op(4'b1011, 4'b1101);
    run_op(4'hF, 4'hF);
    run_op(4'h0, 4'h7);
    run_op(4'h9, 4'h6);

    // start held high: ignored while busy, one IDLE cycle between ops
    @(negedge clk);
    da = 4'b1011;
    db = 4'b1101;
    start = 1'b1;
    @(negedge clk);
    seen = 0;
    g = 0;
    while (!done && g < 40) begin
      if (clr) seen++;
      @(negedge clk);
      g++;
    end
    check("held_done", int'(done), 1);
    check("held_one_clr", seen, 1);
    @(negedge clk);
    check("gap_busy", int'(busy), 0);
    check("gap_clr", int'(clr), 0);
    @(negedge clk);
    check("restart_clr", int'(clr), 1);
    start = 1'b0;
    wait_done("held_op2_done");
    #1;
    check("held_product", int'(p_r), 143);
    @(negedge clk);

    // reset during the second SHB
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    g = 0;
    while (seen < 2 && g < 40) begin
      @(negedge clk);
      if (shb) seen++;
      g++;
    end
    check("mid_shb_seen", seen, 2);
    clr_n = 1'b0;
    #1;
    check("mid_rst_outs", int'({clr, ld, ldp, shb, shp, busy, done}), 0);
    @(negedge clk);
    clr_n = 1'b1;
    run_op(4'h9, 4'h6);

    check("never_multi_hot", multi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
